// File: rtl/exe_muldiv_unit.sv
// EXE-stage multiply/divide unit: owns architectural HI/LO, runs a fixed-latency
// multiply or a 32-step restoring divide, and stalls the pipeline while busy.
module exe_muldiv_unit #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        EXE_Flush,
    input  logic        EXE_Wr,
    input  logic [2:0]  EXE_MulDivOp,
    input  logic [31:0] EXE_BusA,
    input  logic [31:0] EXE_BusB,
    output logic [31:0] EXE_Hi,
    output logic [31:0] EXE_Lo,
    output logic        EXE_MDU_Stall
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    // opnd_a doubles as the quotient shift register during a divide
    logic [XLEN-1:0]   opnd_a;
    logic [XLEN-1:0]   opnd_b;
    logic [XLEN-1:0]   div_rem;
    logic              mul_signed;
    logic              neg_quo;
    logic              neg_rem;

    logic is_mul;
    logic is_div;
    logic accept;

    assign is_mul = (EXE_MulDivOp == OP_MULT) || (EXE_MulDivOp == OP_MULTU);
    assign is_div = (EXE_MulDivOp == OP_DIV)  || (EXE_MulDivOp == OP_DIVU);
    assign accept = (state == S_IDLE) && (is_mul || is_div) && !EXE_Flush;
    assign EXE_MDU_Stall = accept || (state == S_MUL) || (state == S_DIV);

    // 33-bit magnitudes so that |0x80000000| is representable
    logic            sign_a;
    logic            sign_b;
    logic [XLEN:0]   mag_a;
    logic [XLEN:0]   mag_b;
    logic            unused_mag;

    assign sign_a     = (EXE_MulDivOp == OP_DIV) && EXE_BusA[XLEN-1];
    assign sign_b     = (EXE_MulDivOp == OP_DIV) && EXE_BusB[XLEN-1];
    assign mag_a      = sign_a ? -{1'b0, EXE_BusA} : {1'b0, EXE_BusA};
    assign mag_b      = sign_b ? -{1'b0, EXE_BusB} : {1'b0, EXE_BusB};
    assign unused_mag = mag_a[XLEN] ^ mag_b[XLEN];

    logic signed [2*XLEN-1:0] mul_a_ext;
    logic signed [2*XLEN-1:0] mul_b_ext;
    logic signed [2*XLEN-1:0] product;

    assign mul_a_ext = {{XLEN{mul_signed & opnd_a[XLEN-1]}}, opnd_a};
    assign mul_b_ext = {{XLEN{mul_signed & opnd_b[XLEN-1]}}, opnd_b};
    assign product   = mul_a_ext * mul_b_ext;

    // One restoring-division step: shift in the next dividend bit, trial subtract
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign div_shift = {div_rem, opnd_a[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_b};
    assign div_diff  = div_shift[XLEN-1:0] - opnd_b;
    assign rem_next  = div_ge ? div_diff : div_shift[XLEN-1:0];
    assign quo_next  = {opnd_a[XLEN-2:0], div_ge};
    assign quo_fix   = neg_quo ? -quo_next : quo_next;
    assign rem_fix   = neg_rem ? -rem_next : rem_next;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            opnd_a     <= '0;
            opnd_b     <= '0;
            div_rem    <= '0;
            mul_signed <= 1'b0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
            EXE_Hi     <= '0;
            EXE_Lo     <= '0;
        end else if (EXE_Flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (is_mul) begin
                        opnd_a     <= EXE_BusA;
                        opnd_b     <= EXE_BusB;
                        mul_signed <= (EXE_MulDivOp == OP_MULT);
                        state      <= S_MUL;
                    end else if (is_div) begin
                        opnd_a  <= mag_a[XLEN-1:0];
                        opnd_b  <= mag_b[XLEN-1:0];
                        div_rem <= '0;
                        neg_quo <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        state   <= S_DIV;
                    end else if (EXE_Wr && (EXE_MulDivOp == OP_MTHI)) begin
                        EXE_Hi <= EXE_BusA;
                    end else if (EXE_Wr && (EXE_MulDivOp == OP_MTLO)) begin
                        EXE_Lo <= EXE_BusA;
                    end
                end
                S_MUL: begin
                    if (cnt == MUL_LAST) begin
                        {EXE_Hi, EXE_Lo} <= product;
                        cnt              <= '0;
                        state            <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    opnd_a  <= quo_next;
                    div_rem <= rem_next;
                    if (cnt == DIV_LAST) begin
                        EXE_Lo <= quo_fix;
                        EXE_Hi <= rem_fix;
                        cnt    <= '0;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (EXE_Wr) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
